// File: rtl/encrypt_round_ctrl.sv
// rtl/encrypt_round_ctrl.sv - three-round XOR-key / bit-permutation byte encrypt/decrypt controller
//
// Accepts one byte per transaction and runs NUM_ROUNDS rounds, one per clock.
// Owns the key and permutation register file. The config port updates it
// only while the controller is idle.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   mode       0 = encrypt, 1 = decrypt; sampled when a byte is accepted
//   in_data    input byte
//   in_valid   input byte valid
//   in_ready   controller can accept a byte
//   out_data   result byte, held until the output handshake
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   cfg_we     config write strobe
//   cfg_addr   0-2 = key[0..2], 3-10 = perm[0..7], 11-15 = reserved (ignored)
//   cfg_wdata  write data; perm entries use bits [2:0]
//   cfg_ready  a config write is taken this cycle
//   cfg_err    registered flag: two permutation entries are equal
//   busy       a transaction is in progress
module encrypt_round_ctrl #(
    parameter int NUM_ROUNDS = 3,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [7:0]        cfg_wdata,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic [1:0] LAST_ROUND = 2'(NUM_ROUNDS - 1);

    logic [1:0]        state;
    logic [1:0]        round_cnt;
    logic              mode_q;
    logic [DATA_W-1:0] work;

    logic [DATA_W-1:0] key  [0:NUM_ROUNDS-1];
    logic [IDX_W-1:0]  perm [0:DATA_W-1];

    logic [DATA_W-1:0] p_in;
    logic [DATA_W-1:0] p_out;
    logic [DATA_W-1:0] pinv_out;
    logic [DATA_W-1:0] round_out;
    logic [1:0]        dec_idx;
    logic              perm_dup;
    logic              cfg_take;
    logic [IDX_W-1:0]  perm_idx;

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    // A pending config write takes priority over an incoming byte, so the
    // byte is only accepted once the table it will use has settled.
    assign in_ready  = (state == ST_IDLE) && !cfg_we && !cfg_err;
    assign cfg_take  = cfg_we && cfg_ready;

    // Addresses 3..10 map onto perm[0..7]; subtracting 3 modulo 8 on the low
    // bits gives the entry index without needing the address MSB.
    assign perm_idx = cfg_addr[2:0] - 3'd3;

    // Decrypt walks the keys in reverse order.
    assign dec_idx = LAST_ROUND - round_cnt;

    always_comb begin
        p_in      = work ^ key[round_cnt];
        p_out     = '0;
        pinv_out  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            p_out[i]          = p_in[perm[i]];
            pinv_out[perm[i]] = work[i];
        end
        round_out = mode_q ? (pinv_out ^ key[dec_idx]) : p_out;
    end

    always_comb begin
        perm_dup = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            for (int j = i + 1; j < DATA_W; j++) begin
                if (perm[i] == perm[j]) begin
                    perm_dup = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key[0] <= 8'hDE;
            key[1] <= 8'hAD;
            key[2] <= 8'hBE;
            for (int i = 0; i < DATA_W; i++) begin
                perm[i] <= IDX_W'(DATA_W - 1 - i);
            end
        end else if (cfg_take) begin
            if (cfg_addr < 4'd3) begin
                key[cfg_addr[1:0]] <= cfg_wdata;
            end else if (cfg_addr <= 4'd10) begin
                perm[perm_idx] <= cfg_wdata[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= perm_dup;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            round_cnt <= 2'd0;
            mode_q    <= 1'b0;
            work      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        work      <= in_data;
                        mode_q    <= mode;
                        round_cnt <= 2'd0;
                        state     <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    work <= round_out;
                    if (round_cnt == LAST_ROUND) begin
                        out_data  <= round_out;
                        out_valid <= 1'b1;
                        round_cnt <= 2'd0;
                        state     <= ST_OUT;
                    end else begin
                        round_cnt <= round_cnt + 2'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_round_ctrl.sv
// tb/tb_encrypt_round_ctrl.sv - self-checking bench for encrypt_round_ctrl
module tb_encrypt_round_ctrl;

    logic       clk;
    logic       n_rst;
    logic       mode;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       cfg_ready;
    logic       cfg_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_key  [0:2];
    logic [2:0] m_perm [0:7];

    encrypt_round_ctrl dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_defaults();
        m_key[0] = 8'hDE;
        m_key[1] = 8'hAD;
        m_key[2] = 8'hBE;
        for (int i = 0; i < 8; i++) m_perm[i] = 3'(7 - i);
    endfunction

    // Encrypt: for each round, XOR key then out bit i = in bit perm[i].
    function automatic logic [7:0] m_enc(input logic [7:0] x);
        logic [7:0] d;
        logic [7:0] t;
        d = x;
        for (int r = 0; r < 3; r++) begin
            t = d ^ m_key[r];
            for (int i = 0; i < 8; i++) d[i] = t[m_perm[i]];
        end
        return d;
    endfunction

    // Decrypt as the inverse mapping of encrypt, found by exhaustive search.
    function automatic logic [7:0] m_dec(input logic [7:0] y);
        for (int v = 0; v < 256; v++) begin
            if (m_enc(8'(v)) == y) return 8'(v);
        end
        return 8'hxx;
    endfunction

    task automatic do_reset();
        n_rst     = 1'b0;
        mode      = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 4'h0;
        cfg_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_defaults();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (a < 4'd3) m_key[a] = d;
        else if (a <= 4'd10) m_perm[a - 4'd3] = d[2:0];
    endtask

    task automatic run_byte(input string tag, input logic m, input logic [7:0] d,
                            output logic [7:0] res);
        int k;
        mode      = m;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_accept"}, 32'(k < 50), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_latency"}, k, 32'd3);
        res = out_data;
        @(posedge clk);
        #1;
        chk({tag, "_valid_1cyc"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] res;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] hold;
        logic [2:0] shuf [0:7];
        logic [2:0] tmp;
        int         j;

        do_reset();

        // Reset state
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cfg_ready", cfg_ready, 1'b1);

        // Default tables
        run_byte("enc00", 1'b0, 8'h00, res);
        chk("enc00_const", res, 8'hAB);
        chk("enc00_model", res, m_enc(8'h00));
        run_byte("decAB", 1'b1, 8'hAB, res);
        chk("decAB_const", res, 8'h00);

        // Random loopback with default tables
        for (int n = 0; n < 200; n++) begin
            x = 8'($urandom_range(0, 255));
            run_byte("lb_enc", 1'b0, x, y);
            chk("lb_enc_model", y, m_enc(x));
            run_byte("lb_dec", 1'b1, y, res);
            chk("lb_roundtrip", res, x);
        end

        // Identity permutation
        for (int i = 0; i < 8; i++) cfg_write(4'(3 + i), 8'(i));
        run_byte("id_enc", 1'b0, 8'h00, res);
        chk("id_enc00", res, 8'hCD);

        // Zero keys with identity permutation
        for (int i = 0; i < 3; i++) cfg_write(4'(i), 8'h00);
        run_byte("zk_enc", 1'b0, 8'h5A, res);
        chk("zk_enc5A", res, 8'h5A);

        // Reserved address must not disturb anything
        cfg_write(4'hF, 8'h55);
        cfg_write(4'hB, 8'h13);
        run_byte("rsv_enc", 1'b0, 8'h5A, res);
        chk("rsv_enc5A", res, 8'h5A);

        // Random keys and random bijective permutation
        for (int i = 0; i < 8; i++) shuf[i] = 3'(i);
        for (int i = 7; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = shuf[i];
            shuf[i] = shuf[j];
            shuf[j] = tmp;
        end
        for (int i = 0; i < 3; i++) cfg_write(4'(i), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 8; i++) cfg_write(4'(3 + i), {5'b0, shuf[i]});
        for (int n = 0; n < 20; n++) begin
            x = 8'($urandom_range(0, 255));
            run_byte("rc_enc", 1'b0, x, y);
            chk("rc_enc_model", y, m_enc(x));
            run_byte("rc_dec", 1'b1, y, res);
            chk("rc_dec_model", res, m_dec(y));
            chk("rc_roundtrip", res, x);
        end

        // Reset restores defaults
        do_reset();
        run_byte("rst2_enc", 1'b0, 8'h00, res);
        chk("rst2_enc00", res, 8'hAB);

        // Config write beats a simultaneous byte, byte then uses new key
        mode      = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 4'h0;
        cfg_wdata = 8'h00;
        #1;
        chk("cfgwin_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        m_key[0] = 8'h00;
        chk("cfgwin_not_busy", busy, 1'b0);
        run_byte("cfgwin", 1'b0, 8'h00, res);
        chk("cfgwin_newkey", res, m_enc(8'h00));
        cfg_write(4'h0, 8'hDE);

        // Duplicate permutation entry blocks input until repaired
        cfg_write(4'h3, 8'h01);
        @(posedge clk);
        #1;
        chk("dup_cfg_err", cfg_err, 1'b1);
        mode     = 1'b0;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("dup_in_ready", in_ready, 1'b0);
            chk("dup_busy", busy, 1'b0);
            chk("dup_cfg_ready", cfg_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        cfg_write(4'h3, 8'h07);
        run_byte("fix", 1'b0, 8'h3C, res);
        chk("fix_result", res, m_enc(8'h3C));
        chk("fix_cfg_err", cfg_err, 1'b0);

        // Output stall: data held, input blocked, config write dropped
        mode      = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("stall_busy_round", busy, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_out_valid", out_valid, 1'b1);
        hold = out_data;
        chk("stall_data", hold, 8'hAB);
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold_data", out_data, hold);
            chk("stall_hold_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_cfg_ready", cfg_ready, 1'b0);
            if (i == 4) begin
                cfg_we    = 1'b1;
                cfg_addr  = 4'h0;
                cfg_wdata = 8'h00;
            end else begin
                cfg_we = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release", out_valid, 1'b0);
        chk("stall_idle", busy, 1'b0);
        run_byte("drop", 1'b0, 8'h00, res);
        chk("drop_enc00", res, 8'hAB);

        // Reset during ROUND after key[0] was changed
        cfg_write(4'h0, 8'h00);
        mode     = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b1;
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy", busy, 1'b1);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_err", cfg_err, 1'b0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_defaults();
        @(posedge clk);
        #1;
        run_byte("post_rst", 1'b0, 8'h00, res);
        chk("post_rst_enc00", res, 8'hAB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
